// File: rtl/rgbw_pkg.sv
// Shared constants for the RGBW lamp datapath.
//   WIDTH      default duty width in bits (matches pwmGen duty0..duty3)
//   RATE_W     width of the fade step-size input
//   NUM_CH     number of colour channels
//   CH_R..CH_W channel index of each colour inside per-channel arrays
package rgbw_pkg;

  localparam int WIDTH  = 8;
  localparam int RATE_W = 4;
  localparam int NUM_CH = 4;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int CH_W = 3;

endpackage

// File: rtl/fade_channel.sv
// One colour channel of the duty fader: latched target, ramped duty, and the
// step/clamp logic that moves the duty toward the target by at most `rate`
// LSBs per tick without ever overshooting it.
// Ports:
//   clk, reset  system clock, asynchronous active-low reset
//   tick        fade step enable (already gated by hold at the top level)
//   rate        step size in LSBs; 0 means follow the target instantly
//   target_vld  strobe that loads target_in into the target register
//   target_in   new target duty
//   duty        registered ramped duty
//   at_target   duty equals the latched target
module fade_channel
  import rgbw_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [RATE_W-1:0] rate,
  input  logic              target_vld,
  input  logic [W-1:0]      target_in,
  output logic [W-1:0]      duty,
  output logic              at_target
);

  logic [W-1:0] tgt_q;
  logic [W-1:0] duty_q;
  logic [W-1:0] step_nxt;

  // Distances are formed one bit wider so the comparison against rate can
  // never be fooled by wrap-around. The add/subtract itself only runs when
  // the distance exceeds rate, so it stays inside [0, 2^W-1] at W bits.
  logic [W:0]   d_ext;
  logic [W:0]   t_ext;
  logic [W:0]   r_ext;
  logic [W-1:0] r_w;

  assign d_ext = {1'b0, duty_q};
  assign t_ext = {1'b0, tgt_q};
  assign r_ext = {{(W + 1 - RATE_W){1'b0}}, rate};
  assign r_w   = {{(W - RATE_W){1'b0}}, rate};

  always_comb begin
    step_nxt = duty_q;
    if (t_ext > d_ext) begin
      if ((t_ext - d_ext) <= r_ext) step_nxt = tgt_q;
      else                          step_nxt = duty_q + r_w;
    end else if (t_ext < d_ext) begin
      if ((d_ext - t_ext) <= r_ext) step_nxt = tgt_q;
      else                          step_nxt = duty_q - r_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_q  <= '0;
      duty_q <= '0;
    end else begin
      if (target_vld) tgt_q <= target_in;
      // rate==0 bypasses the prescaler and hold: the duty follows the target
      // every cycle, taking a fresh target straight from the inputs.
      if (rate == '0) begin
        duty_q <= target_vld ? target_in : tgt_q;
      end else if (tick) begin
        // Uses the target register before this edge's load, so a target
        // arriving on a tick edge only steers from the following tick.
        duty_q <= step_nxt;
      end
    end
  end

  assign duty      = duty_q;
  assign at_target = (duty_q == tgt_q);

endmodule

// File: rtl/duty_fader.sv
// Slew-rate limiter between colorGen and pwmGen. Ramps the four PWM duties
// toward the latched colour targets in steps of `rate` LSBs every TICK_DIV
// clocks, turning SPI colour changes into smooth fades.
// Ports:
//   clk, reset            system clock, asynchronous active-low reset
//   hold                  pause the prescaler and freeze the fade
//   rate                  step size per tick; 0 = instant
//   target_vld            1-cycle strobe sampling target_r/g/b/w
//   target_r/g/b/w        new target duties
//   duty_r/g/b/w          registered ramped duties (to pwmGen duty0..3)
//   busy                  registered: some duty differed from its target
//                         after the previous edge
//   done                  1-cycle pulse in the first cycle busy reads 0
module duty_fader
  import rgbw_pkg::*;
#(
  parameter int WIDTH    = rgbw_pkg::WIDTH,
  parameter int TICK_DIV = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [RATE_W-1:0] rate,
  input  logic              target_vld,
  input  logic [WIDTH-1:0]  target_r,
  input  logic [WIDTH-1:0]  target_g,
  input  logic [WIDTH-1:0]  target_b,
  input  logic [WIDTH-1:0]  target_w,
  output logic [WIDTH-1:0]  duty_r,
  output logic [WIDTH-1:0]  duty_g,
  output logic [WIDTH-1:0]  duty_b,
  output logic [WIDTH-1:0]  duty_w,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0] CNT_LAST = 16'(TICK_DIV - 1);

  logic [15:0]      cnt_q;
  logic             tick;
  logic             any_diff;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] tgt_ch  [NUM_CH];
  logic [WIDTH-1:0] duty_ch [NUM_CH];
  logic [NUM_CH-1:0] at_target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= (cnt_q == CNT_LAST) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  assign tick = (cnt_q == CNT_LAST) && !hold;

  assign tgt_ch[CH_R] = target_r;
  assign tgt_ch[CH_G] = target_g;
  assign tgt_ch[CH_B] = target_b;
  assign tgt_ch[CH_W] = target_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fade_channel #(.W(WIDTH)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .rate       (rate),
      .target_vld (target_vld),
      .target_in  (tgt_ch[i]),
      .duty       (duty_ch[i]),
      .at_target  (at_target[i])
    );
  end

  assign duty_r = duty_ch[CH_R];
  assign duty_g = duty_ch[CH_G];
  assign duty_b = duty_ch[CH_B];
  assign duty_w = duty_ch[CH_W];

  assign any_diff = ~&at_target;

  // While held, busy keeps its value and no completion is reported; done is
  // raised together with busy falling so it marks the first idle cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (hold) begin
      done_q <= 1'b0;
    end else begin
      busy_q <= any_diff;
      done_q <= busy_q & ~any_diff;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_duty_fader.sv
module tb_duty_fader;
  import rgbw_pkg::*;

  localparam int W  = 8;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         hold = 1'b0;
  logic [3:0]   rate = '0;
  logic         target_vld = 1'b0;
  logic [W-1:0] target_r = '0, target_g = '0, target_b = '0, target_w = '0;
  logic [W-1:0] duty_r, duty_g, duty_b, duty_w;
  logic         busy, done;

  always #5 clk = ~clk;

  duty_fader #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .rate       (rate),
    .target_vld (target_vld),
    .target_r   (target_r),
    .target_g   (target_g),
    .target_b   (target_b),
    .target_w   (target_w),
    .duty_r     (duty_r),
    .duty_g     (duty_g),
    .duty_b     (duty_b),
    .duty_w     (duty_w),
    .busy       (busy),
    .done       (done)
  );

  // Channel values packed {r, g, b, w}, one byte each.
  typedef struct packed {
    logic [31:0] start;
    logic [31:0] tgt;
    logic [3:0]  rate;
    logic [31:0] expd;
  } vec_t;

  vec_t vecs [6];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tgt(input logic [31:0] v);
    {target_r, target_g, target_b, target_w} = v;
  endtask

  task automatic chk_all(input string name, input logic [31:0] exp);
    chk({name, "_r"}, int'(duty_r), int'(exp[31:24]));
    chk({name, "_g"}, int'(duty_g), int'(exp[23:16]));
    chk({name, "_b"}, int'(duty_b), int'(exp[15:8]));
    chk({name, "_w"}, int'(duty_w), int'(exp[7:0]));
  endtask

  // instant load of all channels (rate 0), leaves target_vld low
  task automatic load_now(input logic [31:0] v);
    rate = 4'd0;
    set_tgt(v);
    target_vld = 1'b1;
    step();
    target_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nchg, ndone, done_at, n, prev, expv;
    int chg_val [3];
    int chg_at  [3];

    vecs[0] = '{start: {8'd0,   8'd0,   8'd0,   8'd0},
                tgt:   {8'd40,  8'd200, 8'd255, 8'd1},   rate: 4'd16 & 4'hF,
                expd:  {8'd16,  8'd16,  8'd16,  8'd1}};
    // rate field is 4 bits, so 16 is not representable; use 15 instead
    vecs[0].rate = 4'd15;
    vecs[0].expd = {8'd15, 8'd15, 8'd15, 8'd1};
    vecs[1] = '{start: {8'd100, 8'd100, 8'd250, 8'd10},
                tgt:   {8'd3,   8'd95,  8'd255, 8'd0},   rate: 4'd5,
                expd:  {8'd95,  8'd95,  8'd255, 8'd5}};
    vecs[2] = '{start: {8'd255, 8'd0,   8'd128, 8'd128},
                tgt:   {8'd0,   8'd255, 8'd128, 8'd120}, rate: 4'd15,
                expd:  {8'd240, 8'd15,  8'd128, 8'd120}};
    vecs[3] = '{start: {8'd250, 8'd5,   8'd7,   8'd60},
                tgt:   {8'd255, 8'd0,   8'd255, 8'd0},   rate: 4'd15,
                expd:  {8'd255, 8'd0,   8'd22,  8'd45}};
    vecs[4] = '{start: {8'd9,   8'd9,   8'd9,   8'd9},
                tgt:   {8'd200, 8'd10,  8'd0,   8'd255}, rate: 4'd0,
                expd:  {8'd200, 8'd10,  8'd0,   8'd255}};
    vecs[5] = '{start: {8'd1,   8'd254, 8'd0,   8'd255},
                tgt:   {8'd0,   8'd255, 8'd255, 8'd0},   rate: 4'd1,
                expd:  {8'd0,   8'd255, 8'd1,   8'd254}};

    // reset state
    #7;
    chk_all("reset", 32'd0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    #1 reset = 1'b1;
    step();
    chk_all("post_reset", 32'd0);
    chk("post_reset_busy", int'(busy), 0);

    // instant load with rate 0
    load_now({8'd200, 8'd10, 8'd0, 8'd255});
    chk_all("instant", {8'd200, 8'd10, 8'd0, 8'd255});
    chk("instant_busy", int'(busy), 0);
    step();
    chk("instant_busy2", int'(busy), 0);
    chk("instant_done", int'(done), 0);

    // single-step table: exactly one effective tick lands in the 4 edges
    // after the new target is taken
    foreach (vecs[k]) begin
      load_now(vecs[k].start);
      rate = vecs[k].rate;
      set_tgt(vecs[k].tgt);
      target_vld = 1'b1;
      step();
      target_vld = 1'b0;
      repeat (4) step();
      chk_all($sformatf("vec%0d", k), vecs[k].expd);
    end

    // ramp up 0 -> 40 at step 16 is not encodable in 4 bits; use rate 15:
    // duty_r 15, 30, 40 on successive ticks
    load_now(32'd0);
    repeat (3) step();
    chk("t3_idle_busy", int'(busy), 0);
    rate = 4'd15;
    set_tgt({8'd40, 8'd0, 8'd0, 8'd0});
    target_vld = 1'b1;
    step();
    target_vld = 1'b0;
    prev = int'(duty_r);
    nchg = 0; ndone = 0; done_at = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 1) chk("t3_busy_rise", int'(busy), 1);
      if (int'(duty_r) != prev) begin
        if (nchg < 3) begin
          chg_val[nchg] = int'(duty_r);
          chg_at[nchg]  = i;
        end
        nchg++;
        prev = int'(duty_r);
      end
      if (done) begin
        ndone++;
        done_at = i;
        chk("t3_busy_at_done", int'(busy), 0);
      end
    end
    chk("t3_nchg", nchg, 3);
    if (nchg >= 3) begin
      chk("t3_val0", chg_val[0], 15);
      chk("t3_val1", chg_val[1], 30);
      chk("t3_val2", chg_val[2], 40);
      chk("t3_gap0", chg_at[1] - chg_at[0], TD);
      chk("t3_gap1", chg_at[2] - chg_at[1], TD);
      chk("t3_done_at", done_at, chg_at[2] + 1);
    end
    chk("t3_ndone", ndone, 1);
    chk("t3_busy_end", int'(busy), 0);

    // ramp down 100 -> 3 at rate 5 with clamped last step
    load_now({8'd0, 8'd0, 8'd0, 8'd100});
    step();
    rate = 4'd5;
    set_tgt({8'd0, 8'd0, 8'd0, 8'd3});
    target_vld = 1'b1;
    step();
    target_vld = 1'b0;
    prev = int'(duty_w);
    expv = 100;
    nchg = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (int'(duty_w) != prev) begin
        expv = (expv > 8) ? expv - 5 : 3;
        chk("t4_step", int'(duty_w), expv);
        nchg++;
        prev = int'(duty_w);
      end
    end
    chk("t4_nchg", nchg, 20);
    chk("t4_final", int'(duty_w), 3);

    // hold mid-fade for 10 clocks
    load_now(32'd0);
    step();
    rate = 4'd10;
    set_tgt({8'd200, 8'd0, 8'd0, 8'd0});
    target_vld = 1'b1;
    step();
    target_vld = 1'b0;
    n = 0;
    while (duty_r == 8'd0 && n < 8) begin step(); n++; end
    chk("t5_first", int'(duty_r), 10);
    n = 0;
    while (duty_r == 8'd10 && n < 8) begin step(); n++; end
    chk("t5_gap_pre", n, TD);
    chk("t5_second", int'(duty_r), 20);
    step();
    hold = 1'b1;
    repeat (10) begin
      step();
      chk("t5_frozen", int'(duty_r), 20);
    end
    chk("t5_busy_held", int'(busy), 1);
    hold = 1'b0;
    n = 0;
    while (duty_r == 8'd20 && n < 10) begin step(); n++; end
    chk("t5_resume_gap", n, 3);
    chk("t5_third", int'(duty_r), 30);
    n = 0;
    while (duty_r == 8'd30 && n < 10) begin step(); n++; end
    chk("t5_gap_post", n, TD);
    chk("t5_fourth", int'(duty_r), 40);

    // reset mid-fade aborts at once
    reset = 1'b0;
    #1;
    chk_all("t1_abort", 32'd0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_done", int'(done), 0);
    #1 reset = 1'b1;

    // prescaler restarts from 0, so the 4th edge after release is a tick:
    // target 0 arrives on that tick while the old target 50 still steers
    load_now({8'd20, 8'd0, 8'd0, 8'd0});
    chk("t6_load", int'(duty_r), 20);
    chk("t1_no_done1", int'(done), 0);
    rate = 4'd10;
    set_tgt({8'd50, 8'd0, 8'd0, 8'd0});
    target_vld = 1'b1;
    step();
    target_vld = 1'b0;
    chk("t1_no_done2", int'(done), 0);
    step();
    chk("t6_pre_tick", int'(duty_r), 20);
    chk("t1_no_done3", int'(done), 0);
    set_tgt(32'd0);
    target_vld = 1'b1;
    step();
    target_vld = 1'b0;
    chk("t6_old_target", int'(duty_r), 30);
    repeat (3) step();
    chk("t6_wait", int'(duty_r), 30);
    step();
    chk("t6_down1", int'(duty_r), 20);
    repeat (4) step();
    chk("t6_down2", int'(duty_r), 10);
    repeat (4) step();
    chk("t6_down3", int'(duty_r), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
